// File: rtl/pico_sim.sv
// pico_sim: streaming Smith-Waterman scorer.
// A header beat {L, N, S, T} is followed by N query beats of 64 bases each.
// Every query is scored against reference bases S..S+L-1 (wrapping modulo
// the reference size) at one matrix cell per clock. A hit record is emitted
// for each column whose maximum reaches T, and a done record closes each query.
// Optional feature: define PICO_SIM_SCORE_EN to report the column maximum in
// hit bits [63:48]; otherwise those bits are driven 0.
module pico_sim #(
  parameter int REF_WORDS = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_in_valid,
  output logic                         s_in_ready,
  input  logic [127:0]                 s_in_data,
  output logic                         s_out_valid,
  input  logic                         s_out_ready,
  output logic [127:0]                 s_out_data,
  input  logic                         ref_we,
  input  logic [$clog2(REF_WORDS)-1:0] ref_addr,
  input  logic [127:0]                 ref_wdata
);

  localparam int              DATA_W    = 128;
  localparam int              TOT       = REF_WORDS * 64;
  localparam int              BW        = $clog2(TOT);
  localparam logic [31:0]     TOT32     = 32'(TOT);
  localparam logic [BW-1:0]   LAST_BASE = BW'(TOT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_Q    = 3'd1,
    COMPUTE   = 3'd2,
    EMIT_HIT  = 3'd3,
    EMIT_DONE = 3'd4
  } state_t;

  // Saturating +2 for a match on the diagonal.
  function automatic logic [15:0] sat_add2(input logic [15:0] v);
    return (v >= 16'hFFFE) ? 16'hFFFF : v + 16'd2;
  endfunction

  // Subtract one, clamped at zero (the max(0, ...) floor of the recurrence).
  function automatic logic [15:0] floor_dec(input logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : v - 16'd1;
  endfunction

  function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t              state, state_nx;

  // Command and per-query control
  logic [31:0]         len, nq, thr;
  logic [31:0]         q_idx, col_cnt, hit_cnt;
  logic [BW-1:0]       s_base, col_base, col_base_nx;
  logic [5:0]          row;

  // Datapath storage (no reset: always written before being read)
  logic [DATA_W-1:0]   q_reg;
  logic [15:0]         prev_col [64];
  logic [15:0]         up_p1, diag_p1, col_max_p1;
  logic [DATA_W-1:0]   ref_mem [REF_WORDS];

  // Combinational cell evaluation
  logic                hdr_go, q_fire, col_done, cell_en, last_row, hit, more_q;
  logic [DATA_W-1:0]   ref_word;
  logic [1:0]          r_base, q_base;
  logic [15:0]         left_v, up_v, diag_v, diag_term, h_p0, col_max_now;
  logic [15:0]         score_field;
  logic [DATA_W-1:0]   hit_rec, done_rec;

  assign hdr_go   = (state == IDLE) && s_in_valid && (s_in_data[95:64] != 32'd0);
  assign q_fire   = (state == LOAD_Q) && s_in_valid;
  assign col_done = (col_cnt == len);
  assign cell_en  = (state == COMPUTE) && !col_done;
  assign last_row = (row == 6'd63);
  assign more_q   = ((q_idx + 32'd1) < nq);

  assign col_base_nx = (col_base == LAST_BASE) ? '0 : col_base + 1'b1;

  assign ref_word = ref_mem[col_base[BW-1:6]];
  assign r_base   = ref_word[{col_base[5:0], 1'b0} +: 2];
  assign q_base   = q_reg[{row, 1'b0} +: 2];

  // One Smith-Waterman cell: first row and first column see a zero boundary.
  // diag_p1 holds the previous column's value for the row above, captured
  // before that entry was overwritten with the current column.
  always_comb begin
    left_v      = (col_cnt == 32'd0) ? 16'd0 : prev_col[row];
    up_v        = (row == 6'd0) ? 16'd0 : up_p1;
    diag_v      = ((row == 6'd0) || (col_cnt == 32'd0)) ? 16'd0 : diag_p1;
    diag_term   = (q_base == r_base) ? sat_add2(diag_v) : floor_dec(diag_v);
    h_p0        = max16(diag_term, max16(floor_dec(up_v), floor_dec(left_v)));
    col_max_now = (row == 6'd0) ? h_p0 : max16(col_max_p1, h_p0);
    hit         = last_row && ({16'd0, col_max_now} >= thr);
  end

`ifdef PICO_SIM_SCORE_EN
  assign score_field = col_max_now;
`else
  assign score_field = 16'd0;
`endif

  assign hit_rec  = {64'd0, score_field, q_idx[15:0], 32'(col_base)};
  assign done_rec = {1'b1, 79'd0, q_idx[15:0], hit_cnt};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (hdr_go) state_nx = LOAD_Q;
      LOAD_Q:    if (s_in_valid) state_nx = COMPUTE;
      COMPUTE: begin
        if (col_done)  state_nx = EMIT_DONE;
        else if (hit)  state_nx = EMIT_HIT;
      end
      EMIT_HIT:  if (s_out_ready) state_nx = COMPUTE;
      EMIT_DONE: if (s_out_ready) state_nx = more_q ? LOAD_Q : IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Stream handshake outputs decoded from state
  always_comb begin
    s_in_ready  = (state == IDLE) || (state == LOAD_Q);
    s_out_valid = (state == EMIT_HIT) || (state == EMIT_DONE);
  end

  // Command registers, counters and the output record register.
  // The record is loaded only when entering an emit state, so it stays
  // stable for as long as the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len        <= '0;
      nq         <= '0;
      thr        <= '0;
      s_base     <= '0;
      q_idx      <= '0;
      row        <= '0;
      col_cnt    <= '0;
      hit_cnt    <= '0;
      col_base   <= '0;
      s_out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hdr_go) begin
            len    <= s_in_data[127:96];
            nq     <= s_in_data[95:64];
            s_base <= BW'(s_in_data[63:32] % TOT32);
            thr    <= s_in_data[31:0];
            q_idx  <= '0;
          end
        end
        LOAD_Q: begin
          if (q_fire) begin
            row      <= '0;
            col_cnt  <= '0;
            hit_cnt  <= '0;
            col_base <= s_base;
          end
        end
        COMPUTE: begin
          if (col_done) begin
            s_out_data <= done_rec;
          end else begin
            row <= row + 6'd1;
            if (last_row) begin
              col_cnt  <= col_cnt + 32'd1;
              col_base <= col_base_nx;
              if (hit) begin
                hit_cnt    <= hit_cnt + 32'd1;
                s_out_data <= hit_rec;
              end
            end
          end
        end
        EMIT_DONE: begin
          if (s_out_ready) q_idx <= q_idx + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // Query capture and per-cell datapath state
  always_ff @(posedge clk) begin
    if (q_fire) q_reg <= s_in_data;
    if (cell_en) begin
      prev_col[row] <= h_p0;
      up_p1         <= h_p0;
      diag_p1       <= left_v;
      col_max_p1    <= col_max_now;
    end
  end

  // Reference RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (ref_we) ref_mem[ref_addr] <= ref_wdata;
  end

endmodule

// File: tb/tb_pico_sim.sv
module tb_pico_sim;

  localparam int REF_WORDS = 64;
  localparam int TOT       = REF_WORDS * 64;

`ifdef PICO_SIM_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_in_valid;
  logic         s_in_ready;
  logic [127:0] s_in_data;
  logic         s_out_valid;
  logic         s_out_ready;
  logic [127:0] s_out_data;
  logic         ref_we;
  logic [5:0]   ref_addr;
  logic [127:0] ref_wdata;

  pico_sim #(.REF_WORDS(REF_WORDS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_in_valid  (s_in_valid),
    .s_in_ready  (s_in_ready),
    .s_in_data   (s_in_data),
    .s_out_valid (s_out_valid),
    .s_out_ready (s_out_ready),
    .s_out_data  (s_out_data),
    .ref_we      (ref_we),
    .ref_addr    (ref_addr),
    .ref_wdata   (ref_wdata)
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] ref_model [REF_WORDS];
  logic [127:0] qbuf [4];
  logic [127:0] exp_q [$];
  logic [127:0] got [$];
  int           done_seen = 0;
  bit           rand_ready = 1'b0;
  bit           hold_ready = 1'b1;

  typedef struct {
    logic [1:0]  rfill;
    logic [1:0]  qfill;
    int unsigned len;
    int unsigned s;
    int unsigned t;
    int          hits;
    int          first_col;
    int          first_score;
  } vec_t;

  vec_t tbl [5];

  // Output collector: a beat transfers at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && s_out_valid && s_out_ready) begin
      got.push_back(s_out_data);
      if (s_out_data[127]) done_seen = done_seen + 1;
    end
  end

  // Sole driver of s_out_ready.
  initial begin
    s_out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      s_out_ready = rand_ready ? ($urandom_range(0, 9) < 7) : hold_ready;
    end
  end

  function automatic logic [127:0] mk_hit(int unsigned score, int unsigned qi, int unsigned col);
    return {64'd0, (SCORE_EN ? 16'(score) : 16'd0), 16'(qi), 32'(col)};
  endfunction

  function automatic logic [127:0] mk_done(int unsigned qi, int unsigned cnt);
    return {1'b1, 79'd0, 16'(qi), 32'(cnt)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_write(input int addr, input logic [127:0] d);
    ref_we = 1'b1;
    ref_addr = 6'(addr);
    ref_wdata = d;
    ref_model[addr] = d;
    tick();
    ref_we = 1'b0;
  endtask

  task automatic fill_ref(input logic [1:0] b);
    for (int w = 0; w < REF_WORDS; w++) ref_write(w, {64{b}});
  endtask

  task automatic send_beat(input logic [127:0] d);
    int n = 0;
    s_in_valid = 1'b1;
    s_in_data  = d;
    while (!s_in_ready && n < 20000) begin
      tick();
      n++;
    end
    if (!s_in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout: got ready=0 expected ready=1");
    end
    tick();
    s_in_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int target, input int budget);
    int n = 0;
    while ((done_seen - base) < target && n < budget) begin
      tick();
      n++;
    end
    n_vec++;
    if ((done_seen - base) < target) begin
      n_err++;
      $display("FAIL done_timeout: got %0d done records expected %0d", done_seen - base, target);
    end
  endtask

  // Reference model: full local-alignment matrix, column by column, from the
  // scoring rule with plain integer arithmetic.
  task automatic model_cmd(input int unsigned len, input int unsigned nq,
                           input int unsigned s, input int unsigned t);
    int prev [65];
    int cur  [65];
    exp_q.delete();
    for (int qi = 0; qi < int'(nq); qi++) begin
      int hits = 0;
      logic [127:0] qw = qbuf[qi];
      for (int i = 0; i <= 64; i++) prev[i] = 0;
      for (int c = 0; c < int'(len); c++) begin
        int unsigned idx = (s + c) % TOT;
        logic [127:0] rw = ref_model[idx / 64];
        logic [1:0] rb = rw[2 * (idx % 64) +: 2];
        int mx = 0;
        cur[0] = 0;
        for (int i = 1; i <= 64; i++) begin
          logic [1:0] qb = qw[2 * (i - 1) +: 2];
          int d = prev[i - 1] + ((qb == rb) ? 2 : -1);
          int v = 0;
          if (d > 65535) d = 65535;
          if (d > v) v = d;
          if (cur[i - 1] - 1 > v) v = cur[i - 1] - 1;
          if (prev[i] - 1 > v) v = prev[i] - 1;
          cur[i] = v;
          if (v > mx) mx = v;
        end
        if (longint'(mx) >= longint'(t)) begin
          exp_q.push_back(mk_hit(mx, qi, idx));
          hits++;
        end
        for (int i = 0; i <= 64; i++) prev[i] = cur[i];
      end
      exp_q.push_back(mk_done(qi, hits));
    end
  endtask

  // Issue one command and compare every output record with the model.
  task automatic run_cmd(input int unsigned len, input int unsigned nq,
                         input int unsigned s, input int unsigned t, output int g0);
    int d0;
    int ng;
    model_cmd(len, nq, s, t);
    g0 = got.size();
    d0 = done_seen;
    send_beat({32'(len), 32'(nq), 32'(s), 32'(t)});
    for (int qi = 0; qi < int'(nq); qi++) send_beat(qbuf[qi]);
    wait_done(d0, nq, nq * (len * 70 + 300) + 500);
    repeat (5) tick();
    ng = got.size() - g0;
    chk("record_count", 128'(ng), 128'(exp_q.size()));
    for (int k = 0; k < ng && k < exp_q.size(); k++)
      chk($sformatf("record[%0d]", k), got[g0 + k], exp_q[k]);
  endtask

  initial begin
    int g0;
    int hits;
    int first;
    logic [127:0] snap;
    int n;

    tbl[0] = '{2'd0, 2'd0, 128, 0,    128, 65, 63,   128};
    tbl[1] = '{2'd1, 2'd0, 8,   0,    8,   0,  0,    0};
    tbl[2] = '{2'd0, 2'd0, 10,  100,  1,   10, 100,  2};
    tbl[3] = '{2'd2, 2'd2, 4,   4094, 6,   2,  0,    6};
    tbl[4] = '{2'd0, 2'd0, 2,   4095, 0,   2,  4095, 2};

    rst_n = 1'b0;
    s_in_valid = 1'b0;
    s_in_data = '0;
    ref_we = 1'b0;
    ref_addr = '0;
    ref_wdata = '0;
    repeat (3) tick();
    chk("reset_out_valid", 128'(s_out_valid), 128'd0);
    chk("reset_in_ready", 128'(s_in_ready), 128'd1);
    chk("reset_out_data", s_out_data, 128'd0);
    rst_n = 1'b1;
    tick();

    // Directed table: uniform reference and query fills.
    for (int v = 0; v < 5; v++) begin
      fill_ref(tbl[v].rfill);
      qbuf[0] = {64{tbl[v].qfill}};
      run_cmd(tbl[v].len, 1, tbl[v].s, tbl[v].t, g0);
      hits = 0;
      first = -1;
      for (int k = g0; k < got.size(); k++) begin
        if (!got[k][127]) begin
          if (first < 0) first = k;
          hits++;
        end
      end
      chk($sformatf("tbl%0d_hits", v), 128'(hits), 128'(tbl[v].hits));
      if (first >= 0) begin
        chk($sformatf("tbl%0d_first_hit", v), got[first],
            mk_hit(tbl[v].first_score, 0, tbl[v].first_col));
      end
      if (got.size() > g0)
        chk($sformatf("tbl%0d_done", v), got[got.size() - 1], mk_done(0, tbl[v].hits));
    end

    // Back-pressure on a hit record (reference currently all A).
    qbuf[0] = '0;
    hold_ready = 1'b0;
    tick();
    g0 = got.size();
    n = done_seen;
    send_beat({32'd2, 32'd1, 32'd0, 32'd2});
    send_beat(qbuf[0]);
    begin
      int w = 0;
      while (!s_out_valid && w < 1000) begin
        tick();
        w++;
      end
    end
    snap = s_out_data;
    chk("bp_first_record", snap, mk_hit(2, 0, 0));
    repeat (10) begin
      tick();
      chk("bp_valid_held", 128'(s_out_valid), 128'd1);
      chk("bp_data_held", s_out_data, snap);
    end
    hold_ready = 1'b1;
    wait_done(n, 1, 2000);
    repeat (5) tick();
    chk("bp_record_count", 128'(got.size() - g0), 128'd3);
    if (got.size() - g0 >= 3) begin
      chk("bp_rec0", got[g0], snap);
      chk("bp_rec1", got[g0 + 1], mk_hit(4, 0, 1));
      chk("bp_rec2", got[g0 + 2], mk_done(0, 2));
    end

    // Two queries with an empty reference window.
    qbuf[0] = {4{$urandom()}};
    qbuf[1] = {4{$urandom()}};
    run_cmd(0, 2, 7, 5, g0);
    if (got.size() - g0 >= 2) begin
      chk("multi_done0", got[g0], mk_done(0, 0));
      chk("multi_done1", got[g0 + 1], mk_done(1, 0));
    end
    chk("multi_idle_ready", 128'(s_in_ready), 128'd1);

    // Zero query count: header is consumed, nothing is produced.
    g0 = got.size();
    send_beat({32'd5, 32'd0, 32'd0, 32'd0});
    repeat (20) tick();
    chk("n0_no_output", 128'(got.size() - g0), 128'd0);
    chk("n0_in_ready", 128'(s_in_ready), 128'd1);
    chk("n0_out_valid", 128'(s_out_valid), 128'd0);

    // Reset in the middle of a command; the reference must survive.
    qbuf[0] = '0;
    send_beat({32'd128, 32'd1, 32'd0, 32'd128});
    send_beat(qbuf[0]);
    repeat (200) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(s_out_valid), 128'd0);
    chk("midrst_in_ready", 128'(s_in_ready), 128'd1);
    chk("midrst_out_data", s_out_data, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_cmd(2, 1, 0, 2, g0);
    if (got.size() - g0 >= 3)
      chk("midrst_ref_kept", got[g0 + 2], mk_done(0, 2));

    // Randomized commands with random output back-pressure.
    for (int w = 0; w < REF_WORDS; w++)
      ref_write(w, {$urandom(), $urandom(), $urandom(), $urandom()});
    rand_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      int unsigned nq = $urandom_range(1, 2);
      for (int qi = 0; qi < 2; qi++)
        qbuf[qi] = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_cmd($urandom_range(0, 24), nq, $urandom_range(0, TOT - 1),
              $urandom_range(0, 14), g0);
    end
    rand_ready = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
